// File: rtl/div_issue_ctrl.sv
`timescale 1ns/1ps
// div_issue_ctrl
// ---------------------------------------------------------------------------
// Sequences one DIV/DIVU from the EXE stage through the multi-cycle divider.
// The divider sees each division exactly once. EXE stays stalled until the
// {remainder, quotient} pair returns. The HI/LO write is presented in the
// commit cycle. A pipeline flush cancels an operation that has not been
// issued yet, or drains one that is already in flight, so a stale result
// never reaches HI/LO.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. div_in_valid is withdrawn only on flush, which the divider
// tolerates. The operands are constant while div_in_valid is high. The
// controller never withdraws div_out_ready while a result is owed.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   req_valid/req_signed             EXE DIV/DIVU request (1 = DIV)
//   req_dividend/req_divisor         rs / rt operand values
//   req_ack                          EXE advances this cycle
//   flush                            drop current request and in-flight op
//   div_in_valid/div_in_ready        operand handshake to the divider
//   div_op                           {signed, unsigned}, one-hot while issuing
//   div_dividend/div_divisor         latched operands
//   div_out_valid/div_out_ready      result handshake from the divider
//   div_result                       {remainder, quotient}
//   es_div_stall                     EXE must not advance
//   res_valid                        result is held and ready for commit
//   hi_wdata/lo_wdata/hilo_we        HI/LO write port (remainder/quotient)
//   last_cycles                      issue-to-result cycles of the last
//                                    completed division, saturating
//   dbg_state                        current FSM state (IDLE=0, ISSUE=1,
//                                    WAIT=2, DONE=3, DRAIN=4)
//
// Build option DIV_ZERO_BYPASS_EN: a zero divisor skips the divider and
// completes directly with hi = dividend, lo = all ones, last_cycles = 0.
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_signed,
  input  logic [31:0]      req_dividend,
  input  logic [31:0]      req_divisor,
  input  logic             req_ack,
  input  logic             flush,
  output logic             div_in_valid,
  input  logic             div_in_ready,
  output logic [1:0]       div_op,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  input  logic             div_out_valid,
  output logic             div_out_ready,
  input  logic [63:0]      div_result,
  output logic             es_div_stall,
  output logic             res_valid,
  output logic [31:0]      hi_wdata,
  output logic [31:0]      lo_wdata,
  output logic             hilo_we,
  output logic [CNT_W-1:0] last_cycles,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             op_signed;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             bypass;
  logic             take_result;

  // Saturating increment: the counter sticks at all-ones.
  assign cnt_inc = (&cnt) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  assign accept = (state == IDLE) && req_valid && !flush;

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass = accept && (req_divisor == 32'd0);
`else
  assign bypass = 1'b0;
`endif

  // A result that arrives together with a flush is dropped.
  assign take_result = (state == WAIT) && div_out_valid && !flush;

  always_comb begin
    state_nxt     = state;
    div_in_valid  = 1'b0;
    div_out_ready = 1'b0;
    res_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = bypass ? DONE : ISSUE;
      end
      ISSUE: begin
        div_in_valid = 1'b1;
        // Once the divider has taken the operands, a flush must still
        // consume the result, hence DRAIN rather than IDLE.
        if (div_in_ready) state_nxt = flush ? DRAIN : WAIT;
        else if (flush)   state_nxt = IDLE;
      end
      WAIT: begin
        div_out_ready = 1'b1;
        if (flush)              state_nxt = div_out_valid ? IDLE : DRAIN;
        else if (div_out_valid) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (req_ack || flush) state_nxt = IDLE;
      end
      DRAIN: begin
        div_out_ready = 1'b1;
        if (div_out_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign div_op       = (state == ISSUE) ? {op_signed, !op_signed} : 2'b00;
  // Covers the IDLE cycle in which the request is first seen, so EXE
  // never slips past a DIV before the controller has latched it.
  assign es_div_stall = req_valid && (state != DONE) && !flush;
  assign hilo_we      = res_valid && req_ack && !flush;
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_signed    <= 1'b0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
      cnt          <= '0;
      hi_wdata     <= 32'd0;
      lo_wdata     <= 32'd0;
      last_cycles  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_signed    <= req_signed;
        div_dividend <= req_dividend;
        div_divisor  <= req_divisor;
        cnt          <= '0;
      end else if ((state == ISSUE) || (state == WAIT)) begin
        cnt <= cnt_inc;
      end
      // last_cycles includes the cycle in which the result arrives.
      if (take_result) begin
        hi_wdata    <= div_result[63:32];
        lo_wdata    <= div_result[31:0];
        last_cycles <= cnt_inc;
      end else if (bypass) begin
        hi_wdata    <= req_dividend;
        lo_wdata    <= 32'hFFFF_FFFF;
        last_cycles <= '0;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
`timescale 1ns/1ps
module tb_div_issue_ctrl;

  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             req_valid = 1'b0;
  logic             req_signed = 1'b0;
  logic [31:0]      req_dividend = 32'd0;
  logic [31:0]      req_divisor = 32'd0;
  logic             req_ack = 1'b0;
  logic             flush = 1'b0;
  logic             div_in_valid;
  logic             div_in_ready;
  logic [1:0]       div_op;
  logic [31:0]      div_dividend;
  logic [31:0]      div_divisor;
  logic             div_out_valid;
  logic             div_out_ready;
  logic [63:0]      div_result;
  logic             es_div_stall;
  logic             res_valid;
  logic [31:0]      hi_wdata;
  logic [31:0]      lo_wdata;
  logic             hilo_we;
  logic [CNT_W-1:0] last_cycles;
  logic [2:0]       dbg_state;

  div_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_signed(req_signed),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ack(req_ack), .flush(flush),
    .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
    .div_op(div_op), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_out_valid(div_out_valid), .div_out_ready(div_out_ready),
    .div_result(div_result), .es_div_stall(es_div_stall),
    .res_valid(res_valid), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .hilo_we(hilo_we), .last_cycles(last_cycles), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // MIPS-style division: quotient truncates toward zero, remainder takes the
  // dividend's sign. A zero divisor yields {dividend, all ones}.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  // ---------------- divider model (environment) ----------------
  bit bfm_rand      = 1'b0;
  int bfm_lat       = 5;
  int bfm_rdy_delay = 0;

  initial begin
    bit          busy;
    bit          hs_in;
    bit          hs_out;
    bit          rst_s;
    bit          vin;
    int          due;
    int          seen;
    logic [63:0] res;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [1:0]  op_s;
    busy = 0; seen = 0; due = 0; res = '0;
    div_in_ready = 1'b0; div_out_valid = 1'b0; div_result = '0;
    forever begin
      @(negedge clk);
      rst_s  = reset;
      vin    = div_in_valid;
      hs_in  = div_in_valid && div_in_ready;
      hs_out = div_out_valid && div_out_ready;
      a_s = div_dividend; b_s = div_divisor; op_s = div_op;
      @(posedge clk); #1;
      if (rst_s) begin
        busy = 0; seen = 0; div_out_valid = 1'b0;
      end else begin
        if (hs_out) begin busy = 0; div_out_valid = 1'b0; end
        if (hs_in) begin
          busy = 1;
          seen = 0;
          res  = ref_div(op_s[1], a_s, b_s);
          due  = cyc - 1 + (bfm_rand ? int'($urandom_range(1, 40)) : bfm_lat);
        end else if (vin) seen++;
        else seen = 0;
        if (busy && !div_out_valid && cyc >= due) div_out_valid = 1'b1;
      end
      div_result   = div_out_valid ? res : {$urandom, $urandom};
      div_in_ready = !busy && (bfm_rand ? ($urandom_range(0, 3) != 0) : (seen >= bfm_rdy_delay));
    end
  end

  // ---------------- EXE driver ----------------
  // Called just after a rising edge. Holds the request until it is acked
  // (only while res_valid, with probability ack_pct) or until the
  // flush_at-th cycle (0 = first cycle, -1 = never).
  task automatic exe_req(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int ack_pct);
    int n;
    n = 0;
    req_valid = 1'b1; req_signed = sgn; req_dividend = a; req_divisor = b;
    req_ack = 1'b0;
    flush = (flush_at == 0);
    forever begin
      @(posedge clk); #1;
      if (req_ack || flush) break;
      n++;
      if (n > 3000) begin
        n_checks++;
        $display("FAIL exe_req_timeout: request open %0d cycles, required completion within 3000", n);
        break;
      end
      if (n == flush_at) flush = 1'b1;
      else if (res_valid && ($urandom_range(1, 100) <= ack_pct)) req_ack = 1'b1;
    end
    req_valid = 1'b0; req_ack = 1'b0; flush = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin @(posedge clk); #1; end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Transaction-level view: a request is pending issue, owned by the divider
  // (possibly stale after a flush), or holding a result for commit.
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  bit          chk_en = 1'b0;
  bit          m_pend = 0, m_busy = 0, m_stale = 0, m_have = 0;
  logic        m_sgn = 1'b0;
  logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;
  int          m_start = 0, m_last = 0, lat = 0;

  int          commit_cnt = 0, in_hs_cnt = 0;
  logic [31:0] last_commit_hi = '0, last_commit_lo = '0;
  logic [1:0]  last_op_hs = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (div_in_valid && div_in_ready) begin in_hs_cnt++; last_op_hs = div_op; end
      if (hilo_we) begin commit_cnt++; last_commit_hi = hi_wdata; last_commit_lo = lo_wdata; end
    end
    if (chk_en) begin
      check("div_in_valid", div_in_valid, m_pend);
      check("div_op", div_op, m_pend ? {m_sgn, ~m_sgn} : 2'b00);
      check("div_dividend", div_dividend, m_a);
      check("div_divisor", div_divisor, m_b);
      check("div_out_ready", div_out_ready, m_busy);
      check("res_valid", res_valid, m_have);
      check("es_div_stall", es_div_stall, req_valid && !flush && !m_have);
      check("hilo_we", hilo_we, m_have && req_ack && !flush);
      check("hi_wdata", hi_wdata, m_hi);
      check("lo_wdata", lo_wdata, m_lo);
      check("last_cycles", last_cycles, m_last);
      if (hilo_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL commit_unexpected: hilo_we with hi=0x%0h lo=0x%0h, required no write", hi_wdata, lo_wdata);
        end else begin
          exp_v = exp_q.pop_front();
          check("commit_hilo", {hi_wdata, lo_wdata}, exp_v);
        end
      end
    end
    // advance the model with this cycle's inputs
    if (reset) begin
      m_pend = 0; m_busy = 0; m_stale = 0; m_have = 0;
      m_sgn = 1'b0; m_a = '0; m_b = '0; m_hi = '0; m_lo = '0; m_last = 0;
      exp_q.delete();
    end else begin
      if (m_have) begin
        if (flush || req_ack) m_have = 0;
      end else if (m_pend) begin
        if (div_in_ready) begin m_pend = 0; m_busy = 1; m_stale = flush; end
        else if (flush) m_pend = 0;
      end else if (m_busy) begin
        if (div_out_valid) begin
          m_busy = 0;
          if (!m_stale && !flush && exp_q.size() > 0) begin
            m_have = 1;
            {m_hi, m_lo} = exp_q[0];
            lat = cyc - m_start + 1;
            m_last = (lat > SAT) ? SAT : lat;
          end
        end else if (flush) m_stale = 1;
      end else if (req_valid && !flush) begin
        m_sgn = req_signed; m_a = req_dividend; m_b = req_divisor;
        exp_q.push_back(ref_div(req_signed, req_dividend, req_divisor));
`ifdef DIV_ZERO_BYPASS_EN
        if (req_divisor == 32'd0) begin
          m_have = 1; m_hi = req_dividend; m_lo = 32'hFFFF_FFFF; m_last = 0;
        end else begin
          m_pend = 1; m_start = cyc + 1;
        end
`else
        m_pend = 1; m_start = cyc + 1;
`endif
      end
      if (flush) exp_q.delete();
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded 900000 ns");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0, h0, n, sel;
    logic [31:0] a, b;

    reset = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_div_in_valid", div_in_valid, 0);
    check("rst_div_out_ready", div_out_ready, 0);
    check("rst_es_div_stall", es_div_stall, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_hilo_we", hilo_we, 0);
    check("rst_div_op", div_op, 0);
    check("rst_operands", {div_dividend, div_divisor}, 0);
    check("rst_hilo", {hi_wdata, lo_wdata}, 0);
    check("rst_last_cycles", last_cycles, 0);
    check("rst_state", dbg_state, 0);
    chk_en = 1'b1;
    @(posedge clk); #1;

    // DIVU 100/7, result 33 cycles after issue
    bfm_lat = 33; bfm_rdy_delay = 0;
    c0 = commit_cnt; h0 = in_hs_cnt;
    exe_req(1'b0, 32'd100, 32'd7, -1, 100);
    check("divu_handshakes", in_hs_cnt - h0, 1);
    check("divu_commits", commit_cnt - c0, 1);
    check("divu_op", last_op_hs, 2'b01);
    check("divu_hi", last_commit_hi, 32'd2);
    check("divu_lo", last_commit_lo, 32'd14);
    check("divu_last_cycles", last_cycles, 34);

    // DIV -7/2 with the divider not ready for 3 cycles
    bfm_lat = 5; bfm_rdy_delay = 3;
    c0 = commit_cnt; h0 = in_hs_cnt;
    exe_req(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 100);
    bfm_rdy_delay = 0;
    check("div_handshakes", in_hs_cnt - h0, 1);
    check("div_op", last_op_hs, 2'b10);
    check("div_hi", last_commit_hi, 32'hFFFF_FFFF);
    check("div_lo", last_commit_lo, 32'hFFFF_FFFD);

    // flush in WAIT, next DIVU 9/3 arrives while the old result is pending
    bfm_lat = 20;
    c0 = commit_cnt; h0 = in_hs_cnt;
    exe_req(1'b0, 32'd50, 32'd5, 5, 100);
    exe_req(1'b0, 32'd9, 32'd3, -1, 100);
    check("flushwait_handshakes", in_hs_cnt - h0, 2);
    check("flushwait_commits", commit_cnt - c0, 1);
    check("flushwait_hi", last_commit_hi, 32'd0);
    check("flushwait_lo", last_commit_lo, 32'd3);

    // flush in DONE
    bfm_lat = 3;
    c0 = commit_cnt;
    exe_req(1'b0, 32'd40, 32'd6, 8, 0);
    check("flushdone_commits", commit_cnt - c0, 0);
    @(negedge clk);
    check("flushdone_res_valid", res_valid, 0);
    @(posedge clk); #1;

    // zero divisor
    bfm_lat = 4;
    c0 = commit_cnt; h0 = in_hs_cnt;
    exe_req(1'b0, 32'h1234_5678, 32'd0, -1, 100);
    check("zero_commits", commit_cnt - c0, 1);
    check("zero_hi", last_commit_hi, 32'h1234_5678);
    check("zero_lo", last_commit_lo, 32'hFFFF_FFFF);
`ifdef DIV_ZERO_BYPASS_EN
    check("zero_handshakes", in_hs_cnt - h0, 0);
    check("zero_last_cycles", last_cycles, 0);
`else
    check("zero_handshakes", in_hs_cnt - h0, 1);
    check("zero_last_cycles", last_cycles, 5);
`endif

    // reset in the middle of a division
    bfm_lat = 200;
    req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd77; req_divisor = 32'd5;
    n = 0;
    while (!div_out_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("midreset_in_wait", div_out_ready, 1);
    idle_cycles(3);
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_outputs",
          {div_in_valid, div_out_ready, es_div_stall, res_valid, hilo_we, div_op}, 0);
    check("midreset_hilo", {hi_wdata, lo_wdata}, 0);
    check("midreset_last_cycles", last_cycles, 0);
    @(posedge clk); #1;
    bfm_lat = 6;
    exe_req(1'b0, 32'd8, 32'd2, -1, 100);
    check("postreset_hi", last_commit_hi, 32'd0);
    check("postreset_lo", last_commit_lo, 32'd4);

    // latency counter saturation
    bfm_lat = 300;
    exe_req(1'b0, 32'd1000, 32'd10, -1, 100);
    check("sat_lo", last_commit_lo, 32'd100);
    check("sat_last_cycles", last_cycles, SAT);

    // back-to-back
    bfm_lat = 1;
    c0 = commit_cnt;
    exe_req(1'b1, 32'd21, 32'd4, -1, 100);
    exe_req(1'b0, 32'd22, 32'd5, -1, 100);
    check("b2b_commits", commit_cnt - c0, 2);
    check("b2b_lo", last_commit_lo, 32'd4);
    check("b2b_hi", last_commit_hi, 32'd2);

    // randomized traffic
    bfm_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (sel < 3) b = $urandom_range(1, 20);
      else if (sel == 3) b = 32'd0;
      else if (sel == 4) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 5) b = 32'hFFFF_FFFF - $urandom_range(0, 8);
      exe_req(1'($urandom_range(0, 1)), a, b,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 30)) : -1, 60);
      idle_cycles($urandom_range(0, 2));
    end
    bfm_rand = 1'b0;
    idle_cycles(60);
    check("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Sequencer that sits between the EXE stage and the multi-cycle divider. It issues each DIV/DIVU to the divider exactly once, using a valid/ready handshake. It holds the EXE stage stalled until the quotient and remainder return, and presents the HI/LO write for the commit cycle. It also cancels or drains in-flight divisions on pipeline flush, so stale results never reach HI/LO.

## Interface
Parameters:
- CNT_W, 8, width of the saturating per-division latency counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  EXE holds a valid DIV/DIVU; held stable until req_ack or flush
- req_signed  in  1  1 = DIV, 0 = DIVU
- req_dividend  in  32  rs value
- req_divisor  in  32  rt value
- req_ack  in  1  EXE advances this cycle (ready_go && ms_allowin)
- flush  in  1  discard current request and any in-flight division
- div_in_valid  out  1  operands valid to divider
- div_in_ready  in  1  divider accepts operands
- div_op  out  2  {signed, unsigned} one-hot to divider
- div_dividend  out  32  latched dividend
- div_divisor  out  32  latched divisor
- div_out_valid  in  1  divider result valid
- div_out_ready  out  1  controller accepts result
- div_result  in  64  {remainder, quotient}
- es_div_stall  out  1  EXE must not advance
- res_valid  out  1  result held and ready for commit
- hi_wdata  out  32  remainder
- lo_wdata  out  32  quotient
- hilo_we  out  1  write HI and LO this cycle
- last_cycles  out  CNT_W  cycles from issue to result for the last completed division, saturating

## Operation
States: IDLE, ISSUE, WAIT, DONE, DRAIN.

- **IDLE.** If req_valid && !flush:
  - Latch dividend, divisor and signed into operand registers.
  - Clear the cycle counter.
  - Go to ISSUE.
- **ISSUE.**
  - div_in_valid = 1.
  - If div_in_valid && div_in_ready, go to WAIT.
  - If flush and no handshake this cycle, go to IDLE; div_in_valid is withdrawn, which the divider tolerates.
  - If flush and handshake in the same cycle, go to DRAIN.
- **WAIT.**
  - div_out_ready = 1.
  - On div_out_valid, latch div_result into hi/lo registers and go to DONE.
  - If flush, go to DRAIN. If div_out_valid arrives in the same cycle as flush, the result is discarded and the state goes to IDLE.
- **DONE.**
  - res_valid = 1; es_div_stall = 0.
  - hilo_we = res_valid && req_ack && !flush.
  - On req_ack or flush, go to IDLE.
- **DRAIN.**
  - div_out_ready = 1. The result is discarded; no HI/LO write.
  - On div_out_valid, go to IDLE.
  - req_valid is ignored in this state.

Stall and outputs:
- es_div_stall = req_valid && (state != DONE) && !flush. It also covers the IDLE cycle in which the request is first seen.
- div_op = {op_signed, !op_signed} while in ISSUE, 2'b00 otherwise.
- Operand registers change only on the IDLE→ISSUE transition; they are constant during ISSUE.

Latency counter:
- Increments each cycle in ISSUE and WAIT, and saturates at all-ones.
- Copied to last_cycles on WAIT→DONE.

## Timing
- **Reset.** State IDLE. div_in_valid, div_out_ready, es_div_stall, res_valid and hilo_we are 0; div_op = 0. Operand registers, hi_wdata, lo_wdata and last_cycles are 0.
- **Request timeline.**
  - Request seen at cycle t.
  - ISSUE at t+1.
  - With div_in_ready = 1 at t+1: WAIT at t+2.
  - div_out_valid at cycle u: DONE at u+1, with es_div_stall low and hilo_we high in the commit cycle.
- **Back-to-back.** DONE+req_ack → IDLE, and the next DIV is accepted in the following cycle.
- **Output timing.** hilo_we is combinational from state, req_ack and flush, and lasts exactly one cycle. hi_wdata and lo_wdata are registered.
- **Mid-operation reset.** Returns to IDLE next edge; the divider is reset by the same signal.

## Configuration
- **DIV_ZERO_BYPASS_EN defined.** In IDLE, req_valid && req_divisor == 0 goes directly to DONE, bypassing the divider:
  - hi_wdata = dividend, lo_wdata = 32'hFFFF_FFFF.
  - last_cycles = 0.
  - div_in_valid never asserts.
- **Undefined.** A zero divisor follows the normal ISSUE/WAIT path, and the result is whatever the divider returns.

## Test plan
- **Normal DIVU.** DIVU 100/7 with in_ready = 1 and out_valid 33 cycles after issue → single div_in_valid handshake, stall until DONE, then hilo_we with hi = 2, lo = 14 and last_cycles = 34.
- **Signed DIV.** DIV −7/2 with div_in_ready low for 3 cycles → div_in_valid held with stable operands and div_op = 2'b10, then hi = 0xFFFFFFFF (−1) and lo = 0xFFFFFFFD (−3).
- **Flush in WAIT.** Flush in WAIT, then next DIVU 9/3 issued while the old result is still pending → state DRAIN, old result consumed without hilo_we, then the new division returns hi = 0, lo = 3.
- **Flush in DONE.** Flush while in DONE → no hilo_we, return to IDLE, res_valid = 0 next cycle.
- **Zero bypass.** Divisor 0 with DIV_ZERO_BYPASS_EN → DONE at t+1, hi = dividend, lo = 0xFFFFFFFF, no div_in_valid. Without the macro → normal issue to the divider.
- **Mid-division reset.** Reset asserted in WAIT → all outputs 0 next cycle. A subsequent DIVU 8/2 completes correctly with hi = 0, lo = 4.
